lane_deskew: RTL and testbench

- Receive-side lane-to-lane deskew stage. Sits directly upstream of the unstriping stage and feeds it lane-aligned data and K flags.
- Each lane's PIPE word is delayed by 0..MAXSKEW-1 cycles so that the COM symbol of an ordered set arrives on every active lane in the same cycle.
- After lock, the block monitors alignment and re-enters search on loss.

---
 rtl/pcie_rx_pkg.sv | 33 +++
 rtl/lane_delay_line.sv | 42 ++++
 rtl/lane_deskew.sv | 176 +++++++++++++++++
 tb/tb_lane_deskew.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_pkg.sv
// -----------------------------------------------------------------------------
// pcie_rx_pkg
// Shared definitions for the receive-side lane stages (deskew, unstriping).
//   COM_SYMBOL      : K28.5 alignment marker byte (valid only with K=1)
//   MAX_LANES       : widest supported link
//   MAX_LANE_BITS   : widest lane word (PIPEWIDTH=32)
//   MAX_LANE_KBITS  : K flags per widest lane word
//   LANE_W          : packed lane word width, {K, data}
//   deskew_state_e  : lane deskew FSM states
//   cfg_supported() : true for PIPEWIDTH 8/16/32 and LANESNUMBER 1/2/4/8/16
// -----------------------------------------------------------------------------
package pcie_rx_pkg;

   localparam logic [7:0] COM_SYMBOL     = 8'hBC;
   localparam int         MAX_LANES      = 16;
   localparam int         MAX_LANE_BITS  = 32;
   localparam int         MAX_LANE_KBITS = 4;
   localparam int         LANE_W         = MAX_LANE_BITS + MAX_LANE_KBITS;

   typedef enum logic {
      SEARCH  = 1'b0,
      ALIGNED = 1'b1
   } deskew_state_e;

   function automatic logic cfg_supported(input logic [5:0] pw, input logic [4:0] ln);
      logic pw_ok;
      logic ln_ok;
      pw_ok = (pw == 6'd8) || (pw == 6'd16) || (pw == 6'd32);
      ln_ok = (ln == 5'd1) || (ln == 5'd2) || (ln == 5'd4) || (ln == 5'd8) || (ln == 5'd16);
      return pw_ok && ln_ok;
   endfunction

endpackage

// File: rtl/lane_delay_line.sv
// -----------------------------------------------------------------------------
// lane_delay_line
// Single-lane delay line with a tap-select mux. Tap 0 is the current input,
// tap k is the input from k cycles earlier (k up to MAXSKEW-1).
//   clk    : clock
//   i_clr  : synchronous clear of the history
//   i_din  : lane word {K[3:0], data[31:0]}
//   i_sel  : tap to present on o_tap
//   o_tap  : selected tap (combinational)
// -----------------------------------------------------------------------------
module lane_delay_line #(
   parameter int MAXSKEW = 4,
   parameter int SEL_W   = 2
) (
   input  logic                           clk,
   input  logic                           i_clr,
   input  logic [pcie_rx_pkg::LANE_W-1:0] i_din,
   input  logic [SEL_W-1:0]               i_sel,
   output logic [pcie_rx_pkg::LANE_W-1:0] o_tap
);
   import pcie_rx_pkg::*;

   logic [LANE_W-1:0] r_hist [1:MAXSKEW-1];

   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int k = 1; k < MAXSKEW; k++) r_hist[k] <= '0;
      end else begin
         r_hist[1] <= i_din;
         for (int k = 2; k < MAXSKEW; k++) r_hist[k] <= r_hist[k-1];
      end
   end

   // Out-of-range selects (non power-of-two depth) fall back to tap 0.
   always_comb begin
      o_tap = i_din;
      for (int k = 1; k < MAXSKEW; k++) begin
         if (int'(i_sel) == k) o_tap = r_hist[k];
      end
   end

endmodule

// File: rtl/lane_deskew.sv
// -----------------------------------------------------------------------------
// lane_deskew
// Receive-side lane-to-lane deskew. Each active lane is delayed by 0..MAXSKEW-1
// words so that ordered-set COM symbols line up across lanes; after lock the
// delayed words are monitored and search restarts on loss of alignment.
//   clk, reset       : clock, synchronous active-high reset
//   PIPEWIDTH        : bits per lane word (8/16/32)
//   LANESNUMBER      : active lanes (1/2/4/8/16)
//   laneData/K       : striped lane words and per-byte K flags
//   deskewedData/K   : same layout, per-lane delayed, registered
//   deskewValid      : high while locked
//   deskewError      : one-cycle pulse on window timeout or alignment loss
// -----------------------------------------------------------------------------
module lane_deskew #(
   parameter int         MAXSKEW    = 4,
   parameter logic [7:0] COM_SYMBOL = 8'hBC
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [5:0]   PIPEWIDTH,
   input  logic [4:0]   LANESNUMBER,
   input  logic [511:0] laneData,
   input  logic [63:0]  laneDataK,
   output logic [511:0] deskewedData,
   output logic [63:0]  deskewedDataK,
   output logic         deskewValid,
   output logic         deskewError
);
   import pcie_rx_pkg::*;

   localparam int               SEL_W = (MAXSKEW > 1) ? $clog2(MAXSKEW) : 1;
   localparam logic [SEL_W-1:0] LAST  = SEL_W'(MAXSKEW - 1);

   logic [LANE_W-1:0]         w_din       [MAX_LANES];
   logic [LANE_W-1:0]         w_tap       [MAX_LANES];
   logic [SEL_W-1:0]          w_sel       [MAX_LANES];
   logic [SEL_W-1:0]          w_arr_now   [MAX_LANES];
   logic [SEL_W-1:0]          w_delay_now [MAX_LANES];
   logic [MAX_LANES-1:0]      w_active, w_com_in, w_com_sel, w_rec_now;
   logic [MAX_LANE_BITS-1:0]  w_dmask;
   logic [MAX_LANE_KBITS-1:0] w_kmask;
   logic                      w_cfg_ok, w_cfg_chg, w_win_now, w_all;
   logic                      w_lock, w_timeout, w_misalign;
   logic [SEL_W-1:0]          w_cnt_cur;
   logic [511:0]              w_asm_data;
   logic [63:0]               w_asm_k;
   int                        w_pw, w_kw;

   deskew_state_e             r_state;
   logic                      r_win;
   logic [SEL_W-1:0]          r_cnt;
   logic [MAX_LANES-1:0]      r_rec;
   logic [SEL_W-1:0]          r_arr   [MAX_LANES];
   logic [SEL_W-1:0]          r_delay [MAX_LANES];
   logic [5:0]                r_pw_prev;
   logic [4:0]                r_ln_prev;
   logic [511:0]              r_data;
   logic [63:0]               r_k;
   logic                      r_valid, r_err;

   // Lane extraction: each lane word is right-aligned and masked to PIPEWIDTH.
   always_comb begin
      w_cfg_ok = cfg_supported(PIPEWIDTH, LANESNUMBER);
      w_cfg_chg = (PIPEWIDTH != r_pw_prev) || (LANESNUMBER != r_ln_prev);
      w_pw = int'(PIPEWIDTH);
      w_kw = w_pw / 8;
      w_dmask = '0;
      w_kmask = '0;
      case (PIPEWIDTH)
         6'd8:    begin w_dmask = 32'h0000_00FF; w_kmask = 4'h1; end
         6'd16:   begin w_dmask = 32'h0000_FFFF; w_kmask = 4'h3; end
         6'd32:   begin w_dmask = 32'hFFFF_FFFF; w_kmask = 4'hF; end
         default: begin w_dmask = '0;            w_kmask = '0;   end
      endcase
      for (int i = 0; i < MAX_LANES; i++) begin
         w_active[i] = w_cfg_ok && (i < int'(LANESNUMBER));
         w_din[i]    = {4'(laneDataK >> (i * w_kw)) & w_kmask,
                        32'(laneData >> (i * w_pw)) & w_dmask};
         w_com_in[i] = w_active[i] && (w_din[i][7:0] == COM_SYMBOL) && w_din[i][32];
      end
   end

   for (genvar g = 0; g < MAX_LANES; g++) begin : g_lane
      lane_delay_line #(.MAXSKEW(MAXSKEW), .SEL_W(SEL_W)) u_dl (
         .clk   (clk),
         .i_clr (reset),
         .i_din (w_din[g]),
         .i_sel (w_sel[g]),
         .o_tap (w_tap[g])
      );
   end

   // Search window: arrivals of this cycle are merged with recorded ones so a
   // completing cycle can lock and steer the taps in the same cycle.
   always_comb begin
      w_cnt_cur = r_win ? r_cnt + 1'b1 : '0;
      w_win_now = r_win || (|w_com_in);
      w_rec_now = r_rec | w_com_in;
      for (int i = 0; i < MAX_LANES; i++) begin
         w_arr_now[i]   = r_rec[i] ? r_arr[i] : w_cnt_cur;
         w_delay_now[i] = w_cnt_cur - w_arr_now[i];
      end
      w_all     = w_win_now && ((w_rec_now & w_active) == w_active);
      w_lock    = (r_state == SEARCH) && w_cfg_ok && w_all;
      w_timeout = (r_state == SEARCH) && w_cfg_ok && r_win && !w_all && (w_cnt_cur == LAST);
      for (int i = 0; i < MAX_LANES; i++) begin
         w_sel[i] = w_lock ? w_delay_now[i] : r_delay[i];
      end
   end

   // Alignment monitor on the selected (delayed) words, plus output assembly.
   always_comb begin
      w_asm_data = '0;
      w_asm_k    = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         w_com_sel[i] = w_active[i] && (w_tap[i][7:0] == COM_SYMBOL) && w_tap[i][32];
         if (w_active[i]) begin
            w_asm_data = w_asm_data | (512'(w_tap[i][31:0] & w_dmask) << (i * w_pw));
            w_asm_k    = w_asm_k | (64'(w_tap[i][35:32] & w_kmask) << (i * w_kw));
         end
      end
      w_misalign = (r_state == ALIGNED) && w_cfg_ok && (|w_com_sel) && (w_com_sel != w_active);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= SEARCH;
         r_win     <= 1'b0;
         r_cnt     <= '0;
         r_rec     <= '0;
         for (int i = 0; i < MAX_LANES; i++) begin
            r_arr[i]   <= '0;
            r_delay[i] <= '0;
         end
         r_pw_prev <= PIPEWIDTH;
         r_ln_prev <= LANESNUMBER;
         r_data    <= '0;
         r_k       <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_pw_prev <= PIPEWIDTH;
         r_ln_prev <= LANESNUMBER;
         r_data    <= w_cfg_ok ? w_asm_data : '0;
         r_k       <= w_cfg_ok ? w_asm_k : '0;
         r_err     <= w_timeout || w_misalign;
         r_valid   <= w_cfg_ok && !w_cfg_chg && (w_lock || ((r_state == ALIGNED) && !w_misalign));
         if (!w_cfg_ok || w_cfg_chg || w_timeout || w_misalign) begin
            r_state <= SEARCH;
            r_win   <= 1'b0;
            r_cnt   <= '0;
            r_rec   <= '0;
            for (int i = 0; i < MAX_LANES; i++) begin
               r_arr[i]   <= '0;
               r_delay[i] <= '0;
            end
         end else if (w_lock) begin
            r_state <= ALIGNED;
            r_win   <= 1'b0;
            r_rec   <= '0;
            for (int i = 0; i < MAX_LANES; i++) r_delay[i] <= w_delay_now[i];
         end else if ((r_state == SEARCH) && w_win_now) begin
            r_win <= 1'b1;
            r_cnt <= w_cnt_cur;
            r_rec <= w_rec_now & w_active;
            for (int i = 0; i < MAX_LANES; i++) r_arr[i] <= w_arr_now[i];
         end
      end
   end

   assign deskewedData  = r_data;
   assign deskewedDataK = r_k;
   assign deskewValid   = r_valid;
   assign deskewError   = r_err;

endmodule

// File: tb/tb_lane_deskew.sv
// -----------------------------------------------------------------------------
// tb_lane_deskew
// Directed bench for lane_deskew (MAXSKEW=4). Lane words are built per lane in
// ld/lk and packed with the current PIPEWIDTH/LANESNUMBER before each edge;
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_lane_deskew;

   logic         clk = 1'b0;
   logic         reset;
   logic [5:0]   PIPEWIDTH;
   logic [4:0]   LANESNUMBER;
   logic [511:0] laneData;
   logic [63:0]  laneDataK;
   logic [511:0] deskewedData;
   logic [63:0]  deskewedDataK;
   logic         deskewValid;
   logic         deskewError;

   logic [31:0]  ld [16];
   logic [3:0]   lk [16];
   logic [5:0]   pw_cfg;
   logic [4:0]   ln_cfg;
   logic [511:0] e_data;
   int           n_chk = 0;
   int           n_err = 0;

   lane_deskew #(.MAXSKEW(4), .COM_SYMBOL(8'hBC)) dut (
      .clk           (clk),
      .reset         (reset),
      .PIPEWIDTH     (PIPEWIDTH),
      .LANESNUMBER   (LANESNUMBER),
      .laneData      (laneData),
      .laneDataK     (laneDataK),
      .deskewedData  (deskewedData),
      .deskewedDataK (deskewedDataK),
      .deskewValid   (deskewValid),
      .deskewError   (deskewError)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_lanes();
      for (int i = 0; i < 16; i++) begin
         ld[i] = '0;
         lk[i] = '0;
      end
   endtask

   task automatic com(input int lane);
      ld[lane] = 32'h0000_00BC;
      lk[lane] = 4'h1;
   endtask

   // Pack lane words, apply, and advance to just after the next rising edge.
   task automatic step();
      logic [511:0] d;
      logic [63:0]  k;
      int           pw, kw;
      pw = int'(pw_cfg);
      kw = pw / 8;
      d  = '0;
      k  = '0;
      for (int i = 0; i < int'(ln_cfg); i++) begin
         d = d | (512'(ld[i]) << (i * pw));
         k = k | (64'(lk[i]) << (i * kw));
      end
      PIPEWIDTH   = pw_cfg;
      LANESNUMBER = ln_cfg;
      laneData    = d;
      laneDataK   = k;
      @(posedge clk);
      #1;
      idle_lanes();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"},  deskewedData, '0);
      chk({tag, "_k"},     512'(deskewedDataK), '0);
      chk({tag, "_valid"}, 512'(deskewValid), '0);
      chk({tag, "_err"},   512'(deskewError), '0);
   endtask

   initial begin
      idle_lanes();
      pw_cfg = 6'd8;
      ln_cfg = 5'd4;
      reset  = 1'b1;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b0;
      step();
      step();

      // Aligned lock: skews 0,1,2,0 -> delays 2,1,0,2
      com(0); com(3); step();
      chk("lock_pre0_valid", 512'(deskewValid), 0);
      com(1); step();
      chk("lock_pre1_valid", 512'(deskewValid), 0);
      com(2); step();
      e_data = '0;
      e_data[31:0] = 32'hBCBC_BCBC;
      chk("lock_valid", 512'(deskewValid), 1);
      chk("lock_data",  deskewedData, e_data);
      chk("lock_k",     512'(deskewedDataK), 512'(64'hF));
      chk("lock_err",   512'(deskewError), 0);
      step();
      chk("hold0_valid", 512'(deskewValid), 1);
      step();
      chk("hold1_valid", 512'(deskewValid), 1);

      // Same skew again: stays aligned, COMs line up on the output
      com(0); com(3); step();
      com(1); step();
      com(2); step();
      chk("again_valid", 512'(deskewValid), 1);
      chk("again_data",  deskewedData, e_data);
      chk("again_err",   512'(deskewError), 0);
      step();
      step();

      // Lane 3 slips by one cycle
      com(0); step();
      chk("slip0_err", 512'(deskewError), 0);
      com(1); com(3); step();
      chk("slip1_valid", 512'(deskewValid), 1);
      com(2); step();
      chk("slip_err",   512'(deskewError), 1);
      chk("slip_valid", 512'(deskewValid), 0);
      step();
      chk("slip_pulse_end", 512'(deskewError), 0);
      step();

      // Relock with skews 0,1,2,1 -> delays 2,1,0,1
      com(0); step();
      com(1); com(3); step();
      com(2); step();
      chk("relock_valid", 512'(deskewValid), 1);
      chk("relock_data",  deskewedData, e_data);
      step();

      // Config change 4 -> 8 lanes while locked
      ln_cfg = 5'd8;
      step();
      chk("cfgchg_valid", 512'(deskewValid), 0);
      chk("cfgchg_err",   512'(deskewError), 0);

      // Open a window, then reset it away mid-SEARCH
      com(0); step();
      reset = 1'b1;
      step();
      chk_all_zero("midreset");
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("postreset_err", 512'(deskewError), 0);
      end
      for (int i = 0; i < 8; i++) com(i);
      step();
      e_data = '0;
      e_data[63:0] = 64'hBCBC_BCBC_BCBC_BCBC;
      chk("lock8_valid", 512'(deskewValid), 1);
      chk("lock8_data",  deskewedData, e_data);
      chk("lock8_k",     512'(deskewedDataK), 512'(64'hFF));

      // Window timeout: PIPEWIDTH=16, 2 lanes, lane 1 four cycles late
      pw_cfg = 6'd16;
      ln_cfg = 5'd2;
      step();
      chk("to_cfg_valid", 512'(deskewValid), 0);
      chk("to_cfg_err",   512'(deskewError), 0);
      step();
      com(0); step();
      chk("to0_err", 512'(deskewError), 0);
      step();
      chk("to1_err", 512'(deskewError), 0);
      step();
      chk("to2_err", 512'(deskewError), 0);
      step();
      chk("to_err",   512'(deskewError), 1);
      chk("to_valid", 512'(deskewValid), 0);
      com(1); step();
      chk("to_pulse_end", 512'(deskewError), 0);
      chk("to4_valid",    512'(deskewValid), 0);
      com(0); com(1); step();
      e_data = '0;
      e_data[31:0] = 32'h00BC_00BC;
      chk("to_lock_valid", 512'(deskewValid), 1);
      chk("to_lock_data",  deskewedData, e_data);
      chk("to_lock_k",     512'(deskewedDataK), 512'(64'h5));
      chk("to_lock_err",   512'(deskewError), 0);

      // Single lane, PIPEWIDTH=32
      pw_cfg = 6'd32;
      ln_cfg = 5'd1;
      step();
      chk("x1_cfg_valid", 512'(deskewValid), 0);
      step();
      com(0); step();
      chk("x1_valid", 512'(deskewValid), 1);
      chk("x1_data",  deskewedData, 512'(32'hBC));
      chk("x1_k",     512'(deskewedDataK), 512'(64'h1));
      step();
      chk("x1_hold_valid", 512'(deskewValid), 1);
      chk("x1_hold_data",  deskewedData, '0);

      // Unsupported PIPEWIDTH=12 with COMs present
      pw_cfg = 6'd12;
      ln_cfg = 5'd4;
      for (int c = 0; c < 4; c++) begin
         if (c < 3) begin
            for (int i = 0; i < 4; i++) com(i);
         end else begin
            com(0);
         end
         step();
         chk_all_zero("unsup");
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
